// File: rtl/div_req_pkg.sv
// div_req_pkg: shared definitions for the div_request operand-entry and
// request controller.
//   - div_req_state_t : request FSM state encoding (IDLE is all-zero, so the
//                       reset value of the exported state reads as IDLE)
//   - DATA_W          : default operand / result width
//   - DEBOUNCE_CYCLES_SIM : short debounce length used by simulation builds
package div_req_pkg;

  localparam int DATA_W              = 8;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4
  } div_req_state_t;

endpackage

// File: rtl/div_request_if.sv
// div_request_if: start/busy bus between the request controller (master)
// and the divider core (slave).
//   div_x, div_y   master -> slave  operands, stable from start until the
//                                   next accepted request
//   div_start      master -> slave  one-cycle start pulse
//   div_busy       slave  -> master divider busy
//   div_z1..div_r2 slave  -> master results, valid once busy has fallen
//
// Handshake: the master raises div_start for exactly one cycle with the
// operands already valid in that cycle. The slave answers by raising
// div_busy (it may already be high in the cycle after div_start) and holds
// it until its results are ready; the falling edge of div_busy marks the
// results valid, and they must stay put until the next div_start. A new
// div_start is never issued while the master is waiting on busy.
interface div_request_if #(
  parameter int DATA_W = div_req_pkg::DATA_W
);

  logic [DATA_W-1:0] div_x;
  logic [DATA_W-1:0] div_y;
  logic              div_start;
  logic              div_busy;
  logic [DATA_W-1:0] div_z1;
  logic [DATA_W-1:0] div_r1;
  logic [DATA_W-1:0] div_z2;
  logic [DATA_W-1:0] div_r2;

  modport master (
    output div_x, div_y, div_start,
    input  div_busy, div_z1, div_r1, div_z2, div_r2
  );

  modport slave (
    input  div_x, div_y, div_start,
    output div_busy, div_z1, div_r1, div_z2, div_r2
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioning for the request controller.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   req      : single-cycle pulse on the debounced press (rising) edge
// The button goes through a 2-flop synchronizer; the debounced level db
// follows the synchronized level only after the two have disagreed for
// DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             db;
  logic             db_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_q  <= db;
      if (sync2 != db) begin
        // This sample is the DEBOUNCE_CYCLES-th consecutive mismatch.
        if (cnt == CNT_LAST) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign req = db & ~db_q;

endmodule

// File: rtl/div_request.sv
// div_request: initiator side of the divider start/busy handshake.
// Debounces the start button, latches the x/y switches as operands, issues
// a one-cycle start pulse, follows busy, and captures the four results.
//   clk, rst           : clock, synchronous active-high reset
//   start_btn          : raw push-button
//   x_sw, y_sw         : dividend / divisor switches
//   bus (master)       : divider bus (div_x/div_y/div_start out, busy/results in)
//   res_z1..res_r2     : captured results, held until the next accepted press
//   res_valid          : captured results are current
//   err_div0           : last press rejected for y = 0 (zero-check builds)
//   err_timeout        : last request saw no busy within BUSY_TIMEOUT cycles
//   state              : current FSM state, for observation
// Build option: define DIV_REQ_ZERO_CHECK_EN to reject requests with y = 0;
// without it y = 0 is issued normally and err_div0 stays 0.
module div_request
  import div_req_pkg::*;
#(
  parameter int DATA_W          = div_req_pkg::DATA_W,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BUSY_TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_btn,
  input  logic [DATA_W-1:0]    x_sw,
  input  logic [DATA_W-1:0]    y_sw,
  div_request_if.master        bus,
  output logic [DATA_W-1:0]    res_z1,
  output logic [DATA_W-1:0]    res_r1,
  output logic [DATA_W-1:0]    res_z2,
  output logic [DATA_W-1:0]    res_r2,
  output logic                 res_valid,
  output logic                 err_div0,
  output logic                 err_timeout,
  output div_req_state_t       state
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  logic              req;
  logic              zero_reject;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] op_x;
  logic [DATA_W-1:0] op_y;
  logic              start_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk (clk),
    .rst (rst),
    .btn (start_btn),
    .req (req)
  );

`ifdef DIV_REQ_ZERO_CHECK_EN
  assign zero_reject = (y_sw == '0);
`else
  assign zero_reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_x        <= '0;
      op_y        <= '0;
      start_q     <= 1'b0;
      to_cnt      <= '0;
      res_z1      <= '0;
      res_r1      <= '0;
      res_z2      <= '0;
      res_r2      <= '0;
      res_valid   <= 1'b0;
      err_div0    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A press seen in any other state is simply dropped.
          if (req) begin
            op_x        <= x_sw;
            op_y        <= y_sw;
            res_valid   <= 1'b0;
            err_div0    <= zero_reject;
            err_timeout <= 1'b0;
            if (!zero_reject) begin
              // Registered so the pulse coincides with the ISSUE cycle.
              start_q <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          to_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Busy wins over an expiring timeout in the same cycle.
          if (bus.div_busy) begin
            state <= ST_WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.div_busy) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          res_z1    <= bus.div_z1;
          res_r1    <= bus.div_r1;
          res_z2    <= bus.div_z2;
          res_r2    <= bus.div_r2;
          res_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.div_x     = op_x;
  assign bus.div_y     = op_y;
  assign bus.div_start = start_q;

endmodule

// File: tb/tb_div_request.sv
// tb_div_request: bench for div_request with a behavioural divider on the bus.
module tb_div_request;
  import div_req_pkg::*;

  localparam int W  = 8;
  localparam int BT = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_btn = 1'b0;
  logic [W-1:0]  x_sw = '0;
  logic [W-1:0]  y_sw = '0;
  logic [W-1:0]  res_z1, res_r1, res_z2, res_r2;
  logic          res_valid, err_div0, err_timeout;
  div_req_state_t state;

  div_request_if #(.DATA_W(W)) bus ();

  div_request #(
    .DATA_W          (W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
    .BUSY_TIMEOUT    (BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .x_sw        (x_sw),
    .y_sw        (y_sw),
    .bus         (bus),
    .res_z1      (res_z1),
    .res_r1      (res_r1),
    .res_z2      (res_z2),
    .res_r2      (res_r2),
    .res_valid   (res_valid),
    .err_div0    (err_div0),
    .err_timeout (err_timeout),
    .state       (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [4*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- divider model ----------------
  function automatic logic [4*W-1:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] h;
    h = x >> 1;
    if (y == '0) return {{W{1'b1}}, x, {W{1'b1}}, h};
    return {W'(x / y), W'(x % y), W'(h / y), W'(h % y)};
  endfunction

  logic           m_busy = 1'b0;
  int             m_cnt = 0;
  logic [4*W-1:0] m_res = '0;
  int             start_cnt = 0;
  bit             model_mute = 1'b0;
  int             busy_len = 10;

  always @(posedge clk) begin
    if (bus.div_start) start_cnt <= start_cnt + 1;
    if (bus.div_start && !model_mute) begin
      m_busy <= 1'b1;
      m_cnt  <= busy_len;
      m_res  <= model_res(bus.div_x, bus.div_y);
    end else if (m_busy) begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  assign bus.div_busy = m_busy;
  assign {bus.div_z1, bus.div_r1, bus.div_z2, bus.div_r2} = m_res;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input div_req_state_t s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state == s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (state == s) ok = 1'b1;
  endtask

  task automatic wait_res_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (res_valid) ok = 1'b1;
  endtask

  task automatic press(input int hold, input int settle);
    start_btn = 1'b1;
    repeat (hold) tick();
    start_btn = 1'b0;
    repeat (settle) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({bus.div_x, bus.div_y, bus.div_start} !== '0) begin
      errors++;
      $display("FAIL reset_div got %h required 0", {bus.div_x, bus.div_y, bus.div_start});
    end
    checks++;
    if ({res_z1, res_r1, res_z2, res_r2, res_valid, err_div0, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_res got %h required 0",
               {res_z1, res_r1, res_z2, res_r2, res_valid, err_div0, err_timeout});
    end
    checks++;
    if (state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d required %0d", state, ST_IDLE);
    end
  endtask

  task automatic test_clean_press();
    int s0;
    int n;
    bit ok;
    logic [4*W-1:0] e;
    s0 = start_cnt;
    busy_len = 10;
    x_sw = 8'd100;
    y_sw = 8'd7;
    exp_q.push_back(model_res(8'd100, 8'd7));
    start_btn = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.div_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clean_start_seen got 0 required 1");
    end
    checks++;
    if ({bus.div_x, bus.div_y} !== {8'd100, 8'd7}) begin
      errors++;
      $display("FAIL clean_operands got %0d/%0d required 100/7", bus.div_x, bus.div_y);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.div_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    for (int i = 0; i < 40 && bus.div_busy; i++) begin
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL clean_valid_during_busy got %b required 0", res_valid);
      end
      tick();
    end
    checks++;
    if (!ok || bus.div_busy) begin
      errors++;
      $display("FAIL clean_busy_cycle got busy=%b seen=%b required busy pulse", bus.div_busy, ok);
    end
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL clean_valid_latency got %0d required 2", n);
    end
    start_btn = 1'b0;
    repeat (12) tick();
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL clean_start_count got %0d required 1", start_cnt - s0);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if ({res_z1, res_r1, res_z2, res_r2} !== e) begin
      errors++;
      $display("FAIL clean_results got %h required %h", {res_z1, res_r1, res_z2, res_r2}, e);
    end
  endtask

  task automatic test_bounce();
    int s0;
    bit ok;
    logic [4*W-1:0] e;
    int hi[4] = '{1, 3, 2, 8};
    s0 = start_cnt;
    busy_len = 6;
    x_sw = 8'd33;
    y_sw = 8'd5;
    exp_q.push_back(model_res(8'd33, 8'd5));
    for (int k = 0; k < 4; k++) begin
      start_btn = 1'b1;
      repeat (hi[k]) tick();
      start_btn = 1'b0;
      repeat (2) tick();
    end
    wait_res_valid(60, ok);
    repeat (12) tick();
    checks++;
    if (!ok || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL bounce_single_start got %0d valid=%b required 1", start_cnt - s0, ok);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if ({res_z1, res_r1, res_z2, res_r2} !== e) begin
      errors++;
      $display("FAIL bounce_results got %h required %h", {res_z1, res_r1, res_z2, res_r2}, e);
    end
    s0 = start_cnt;
    start_btn = 1'b1;
    repeat (3) tick();
    start_btn = 1'b0;
    repeat (20) tick();
    checks++;
    if (start_cnt - s0 != 0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_no_req got starts=%0d valid=%b required 0/1", start_cnt - s0, res_valid);
    end
  endtask

  task automatic test_second_press();
    int s0;
    bit ok;
    logic [4*W-1:0] e;
    s0 = start_cnt;
    busy_len = 30;
    x_sw = 8'd50;
    y_sw = 8'd3;
    exp_q.push_back(model_res(8'd50, 8'd3));
    press(10, 0);
    wait_state(ST_WAIT_DONE, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL second_wait_done got state %0d required %0d", state, ST_WAIT_DONE);
    end
    repeat (8) tick();
    x_sw = 8'd9;
    y_sw = 8'd2;
    press(10, 0);
    checks++;
    if (state !== ST_WAIT_DONE) begin
      errors++;
      $display("FAIL second_press_window got state %0d required %0d", state, ST_WAIT_DONE);
    end
    wait_res_valid(80, ok);
    repeat (12) tick();
    checks++;
    if (!ok || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL second_dropped got %0d valid=%b required 1", start_cnt - s0, ok);
    end
    checks++;
    if ({bus.div_x, bus.div_y} !== {8'd50, 8'd3}) begin
      errors++;
      $display("FAIL second_operands_held got %0d/%0d required 50/3", bus.div_x, bus.div_y);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if ({res_z1, res_r1, res_z2, res_r2} !== e) begin
      errors++;
      $display("FAIL second_results got %h required %h", {res_z1, res_r1, res_z2, res_r2}, e);
    end
  endtask

  task automatic test_timeout();
    int s0;
    int n;
    bit ok;
    logic [4*W-1:0] e;
    s0 = start_cnt;
    model_mute = 1'b1;
    x_sw = 8'd20;
    y_sw = 8'd4;
    start_btn = 1'b1;
    wait_state(ST_WAIT_BUSY, 30, ok);
    n = 0;
    while (state == ST_WAIT_BUSY && n < BT + 10) begin
      tick();
      n++;
    end
    checks++;
    if (!ok || n != BT) begin
      errors++;
      $display("FAIL timeout_cycles got %0d entered=%b required %0d", n, ok, BT);
    end
    checks++;
    if (state !== ST_IDLE || err_timeout !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags got state=%0d err=%b valid=%b required 0/1/0",
               state, err_timeout, res_valid);
    end
    repeat (10) tick();
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL timeout_held_press got %0d required 1", start_cnt - s0);
    end
    start_btn = 1'b0;
    repeat (10) tick();
    model_mute = 1'b0;
    busy_len = 5;
    x_sw = 8'd200;
    y_sw = 8'd9;
    exp_q.push_back(model_res(8'd200, 8'd9));
    press(10, 0);
    wait_res_valid(60, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || {res_z1, res_r1, res_z2, res_r2} !== e || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover got %h err=%b required %h err=0",
               {res_z1, res_r1, res_z2, res_r2}, err_timeout, e);
    end
    repeat (10) tick();
  endtask

  task automatic test_div0();
    int s0;
    bit ok;
    logic [4*W-1:0] e;
    s0 = start_cnt;
    busy_len = 4;
    x_sw = 8'd42;
    y_sw = 8'd0;
`ifdef DIV_REQ_ZERO_CHECK_EN
    press(10, 10);
    checks++;
    if (err_div0 !== 1'b1 || res_valid !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL div0_reject got err=%b valid=%b state=%0d required 1/0/0",
               err_div0, res_valid, state);
    end
    checks++;
    if (start_cnt - s0 != 0) begin
      errors++;
      $display("FAIL div0_no_start got %0d required 0", start_cnt - s0);
    end
`else
    exp_q.push_back(model_res(8'd42, 8'd0));
    press(10, 0);
    wait_res_valid(60, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || {res_z1, res_r1, res_z2, res_r2} !== e || err_div0 !== 1'b0) begin
      errors++;
      $display("FAIL div0_issued got %h err=%b required %h err=0",
               {res_z1, res_r1, res_z2, res_r2}, err_div0, e);
    end
    repeat (10) tick();
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL div0_start got %0d required 1", start_cnt - s0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int s0;
    bit ok;
    logic [4*W-1:0] e;
    s0 = start_cnt;
    busy_len = 40;
    x_sw = 8'd77;
    y_sw = 8'd5;
    press(10, 0);
    wait_state(ST_WAIT_DONE, 40, ok);
    repeat (3) tick();
    checks++;
    if (!ok || state !== ST_WAIT_DONE) begin
      errors++;
      $display("FAIL midrst_reach got state=%0d required %0d", state, ST_WAIT_DONE);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.div_x, bus.div_y, bus.div_start, res_z1, res_r1, res_z2, res_r2,
         res_valid, err_div0, err_timeout} !== '0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL midrst_clear got x=%0d y=%0d valid=%b state=%0d required all 0",
               bus.div_x, bus.div_y, res_valid, state);
    end
    repeat (8) tick();
    busy_len = 6;
    x_sw = 8'd12;
    y_sw = 8'd4;
    exp_q.push_back(model_res(8'd12, 8'd4));
    press(10, 0);
    wait_res_valid(80, ok);
    repeat (10) tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (!ok || {res_z1, res_r1, res_z2, res_r2} !== e) begin
      errors++;
      $display("FAIL midrst_new_req got %h valid=%b required %h",
               {res_z1, res_r1, res_z2, res_r2}, ok, e);
    end
    checks++;
    if (start_cnt - s0 != 2) begin
      errors++;
      $display("FAIL midrst_starts got %0d required 2", start_cnt - s0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_second_press();
    test_timeout();
    test_div0();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
